// File: rtl/cv_bus_master_if.sv
// cv_bus_master_if
//   Z80-style bus seen by the ColecoVision/Adam bus initiator.
//   Signal names are written from the initiator's point of view (_o driven
//   by the initiator, _i driven by the CPU/decoder side).
//
//   busrq_n_o  bus request to the CPU
//   busak_n_i  bus acknowledge from the CPU
//   a_o        address bus
//   d_o        write data, driven onto the bus while d_oe_o = 1
//   d_oe_o     data bus drive enable
//   d_i        read data from the bus
//   mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o  bus strobes
//   wait_n_i   wait request from the addressed device
//
//   Modports: master (the initiator), slave (CPU / decoder / memory side).
interface cv_bus_master_if;
  logic        busrq_n_o;
  logic        busak_n_i;
  logic [15:0] a_o;
  logic [7:0]  d_o;
  logic        d_oe_o;
  logic [7:0]  d_i;
  logic        mreq_n_o;
  logic        iorq_n_o;
  logic        rd_n_o;
  logic        wr_n_o;
  logic        rfsh_n_o;
  logic        wait_n_i;

  modport master (
    output busrq_n_o, a_o, d_o, d_oe_o, mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o,
    input  busak_n_i, d_i, wait_n_i
  );

  modport slave (
    input  busrq_n_o, a_o, d_o, d_oe_o, mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o,
    output busak_n_i, d_i, wait_n_i
  );
endinterface

// File: rtl/cv_bus_master.sv
// cv_bus_master
//   Z80-compatible bus initiator. Executes single-byte memory or I/O commands
//   from an internal agent as T-state-accurate Z80 bus cycles, acquiring the
//   bus from the CPU with BUSRQ/BUSAK and returning it when no command waits.
//
//   Parameters:
//     T_DIV  clocks per T-state (1..15)
//     IO_TW  automatic wait states in every I/O cycle (0..3)
//
//   Build option:
//     CV_BUS_MASTER_WAIT_EN  when defined, wait_n_i = 0 sampled on the last
//                            clock of T2 or of a TW inserts another TW. When
//                            undefined, wait_n_i is ignored.
//
//   Ports:
//     clk_i        system clock
//     reset_i      synchronous reset, active-high
//     req_i        command request
//     we_i         1 = write, 0 = read
//     io_i         1 = I/O cycle, 0 = memory cycle
//     addr_i       command address
//     wdata_i      write data
//     ack_o        one-clock completion pulse
//     rdata_o      read data, valid with ack_o, held until the next read
//     busy_o       high from command acceptance until ack_o
//     bus          Z80 bus (cv_bus_master_if.master)
//     dbg_state_o  current FSM state (IDLE=0 BREQ=1 T1=2 T2=3 TW=4 T3=5)
//
//   Command handshake: the agent raises req_i with we_i/io_i/addr_i/wdata_i
//   stable and keeps it high until it sees ack_o. The command is latched when
//   the bus is granted (busy_o rises); after that it always completes, even if
//   req_i drops. In the clock where ack_o is high the agent either drops req_i
//   (bus is released) or presents the next command with req_i still high (it
//   is latched at the end of that clock and starts in T1 without a new BUSRQ).
module cv_bus_master #(
  parameter int unsigned T_DIV = 2,
  parameter int unsigned IO_TW = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic              io_i,
  input  logic [15:0]       addr_i,
  input  logic [7:0]        wdata_i,
  output logic              ack_o,
  output logic [7:0]        rdata_o,
  output logic              busy_o,
  cv_bus_master_if.master   bus,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BREQ = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_TW   = 3'd4,
    S_T3   = 3'd5
  } state_t;

  localparam logic [3:0] T_LAST  = 4'(T_DIV - 1);
  localparam logic [1:0] IO_TW_L = 2'(IO_TW);

  state_t      state;
  logic [3:0]  tcnt;     // clock within the current T-state
  logic [1:0]  wcnt;     // automatic I/O waits used so far (saturating)
  logic        cmd_we;
  logic        cmd_io;
  logic        t_last;
  logic        auto_wait;
  logic        ext_wait;
  logic        start_cmd;

`ifdef CV_BUS_MASTER_WAIT_EN
  assign ext_wait = ~bus.wait_n_i;
`else
  logic unused_wait_n;
  assign unused_wait_n = bus.wait_n_i;
  assign ext_wait      = 1'b0;
`endif

  assign t_last      = (tcnt == T_LAST);
  assign auto_wait   = cmd_io && (wcnt < IO_TW_L);
  assign bus.rfsh_n_o = 1'b1;
  assign dbg_state_o = state;

  // T3 with ack_o high is the turnaround clock: strobes are already released
  // and a still-asserted request is taken straight into T1.
  always_comb begin
    start_cmd = 1'b0;
    if ((state == S_BREQ) && !bus.busak_n_i)
      start_cmd = 1'b1;
    else if ((state == S_T3) && ack_o && req_i)
      start_cmd = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= S_IDLE;
      tcnt         <= 4'd0;
      wcnt         <= 2'd0;
      cmd_we       <= 1'b0;
      cmd_io       <= 1'b0;
      ack_o        <= 1'b0;
      rdata_o      <= 8'h00;
      busy_o       <= 1'b0;
      bus.busrq_n_o <= 1'b1;
      bus.a_o      <= 16'h0000;
      bus.d_o      <= 8'h00;
      bus.d_oe_o   <= 1'b0;
      bus.mreq_n_o <= 1'b1;
      bus.iorq_n_o <= 1'b1;
      bus.rd_n_o   <= 1'b1;
      bus.wr_n_o   <= 1'b1;
    end else begin
      ack_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_i) begin
            state         <= S_BREQ;
            bus.busrq_n_o <= 1'b0;
          end
        end
        S_BREQ: begin
          // grant is handled by start_cmd below
        end
        S_T1: begin
          if (t_last) begin
            state        <= S_T2;
            tcnt         <= 4'd0;
            bus.mreq_n_o <= cmd_io;
            bus.iorq_n_o <= ~cmd_io;
            bus.rd_n_o   <= cmd_we;
            bus.wr_n_o   <= ~cmd_we;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        S_T2, S_TW: begin
          if (t_last) begin
            tcnt <= 4'd0;
            // Automatic I/O waits are consumed first; an external wait
            // request only adds states beyond them.
            if (auto_wait) begin
              state <= S_TW;
              if (wcnt != 2'd3)
                wcnt <= wcnt + 2'd1;
            end else if (ext_wait) begin
              state <= S_TW;
            end else begin
              state <= S_T3;
            end
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        S_T3: begin
          if (ack_o) begin
            if (!req_i) begin
              state         <= S_IDLE;
              bus.busrq_n_o <= 1'b1;
            end
          end else if (t_last) begin
            ack_o        <= 1'b1;
            busy_o       <= 1'b0;
            tcnt         <= 4'd0;
            if (!cmd_we)
              rdata_o <= bus.d_i;
            bus.d_oe_o   <= 1'b0;
            bus.mreq_n_o <= 1'b1;
            bus.iorq_n_o <= 1'b1;
            bus.rd_n_o   <= 1'b1;
            bus.wr_n_o   <= 1'b1;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (start_cmd) begin
        state      <= S_T1;
        tcnt       <= 4'd0;
        wcnt       <= 2'd0;
        cmd_we     <= we_i;
        cmd_io     <= io_i;
        bus.a_o    <= addr_i;
        bus.d_o    <= wdata_i;
        bus.d_oe_o <= we_i;
        busy_o     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cv_bus_master.sv
module tb_cv_bus_master;

  // Instance A: T_DIV=2, IO_TW=2. Instance B: T_DIV=1, IO_TW=1.
  // Only the selected instance runs; the other is held in reset.
  localparam int TDIV_A = 2;
  localparam int IOTW_A = 2;
  localparam int TDIV_B = 1;
  localparam int IOTW_B = 1;
`ifdef CV_BUS_MASTER_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        io = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        busak_n = 1'b1;
  logic [7:0]  d_in = 8'h00;
  logic        wait_n = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- DUTs ----------------
  cv_bus_master_if bus_a ();
  cv_bus_master_if bus_b ();
  assign bus_a.busak_n_i = busak_n;
  assign bus_a.d_i       = d_in;
  assign bus_a.wait_n_i  = wait_n;
  assign bus_b.busak_n_i = busak_n;
  assign bus_b.d_i       = d_in;
  assign bus_b.wait_n_i  = wait_n;

  logic       ack_a, busy_a, ack_b, busy_b;
  logic [7:0] rdata_a, rdata_b;
  logic [2:0] dbg_a, dbg_b;

  cv_bus_master #(.T_DIV(TDIV_A), .IO_TW(IOTW_A)) u_dut_a (
    .clk_i(clk), .reset_i(rst | sel), .req_i(req), .we_i(we), .io_i(io),
    .addr_i(addr), .wdata_i(wdata), .ack_o(ack_a), .rdata_o(rdata_a),
    .busy_o(busy_a), .bus(bus_a), .dbg_state_o(dbg_a)
  );

  cv_bus_master #(.T_DIV(TDIV_B), .IO_TW(IOTW_B)) u_dut_b (
    .clk_i(clk), .reset_i(rst | ~sel), .req_i(req), .we_i(we), .io_i(io),
    .addr_i(addr), .wdata_i(wdata), .ack_o(ack_b), .rdata_o(rdata_b),
    .busy_o(busy_b), .bus(bus_b), .dbg_state_o(dbg_b)
  );

  logic        o_ack, o_busy, o_busrq_n, o_doe, o_mreq_n, o_iorq_n, o_rd_n, o_wr_n, o_rfsh_n;
  logic [7:0]  o_rdata, o_d;
  logic [15:0] o_a;

  always_comb begin
    o_ack     = sel ? ack_b : ack_a;
    o_busy    = sel ? busy_b : busy_a;
    o_rdata   = sel ? rdata_b : rdata_a;
    o_busrq_n = sel ? bus_b.busrq_n_o : bus_a.busrq_n_o;
    o_a       = sel ? bus_b.a_o : bus_a.a_o;
    o_d       = sel ? bus_b.d_o : bus_a.d_o;
    o_doe     = sel ? bus_b.d_oe_o : bus_a.d_oe_o;
    o_mreq_n  = sel ? bus_b.mreq_n_o : bus_a.mreq_n_o;
    o_iorq_n  = sel ? bus_b.iorq_n_o : bus_a.iorq_n_o;
    o_rd_n    = sel ? bus_b.rd_n_o : bus_a.rd_n_o;
    o_wr_n    = sel ? bus_b.wr_n_o : bus_a.wr_n_o;
    o_rfsh_n  = sel ? bus_b.rfsh_n_o : bus_a.rfsh_n_o;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A granted command is a run of m_len clocks (index m_k from 0). The first
  // T_DIV clocks are address setup, the rest have the strobes low. Each T_DIV
  // clocks after the nominal end of T2 the cycle may be stretched by T_DIV.
  bit          chk_en = 1'b0;
  bit          m_busrq_n, m_in_cyc, m_turn, m_ack, m_we, m_io;
  int          m_k, m_len, m_waits, m_auto;
  logic [15:0] m_a;
  logic [7:0]  m_d, m_rdata;

  task automatic m_start(input int tdiv);
    m_in_cyc = 1'b1;
    m_k      = 0;
    m_len    = 3 * tdiv;
    m_waits  = 0;
    m_auto   = 0;
    m_we     = we;
    m_io     = io;
    m_a      = addr;
    m_d      = wdata;
  endtask

  always @(posedge clk) begin
    int tdiv, iotw;
    tdiv = sel ? TDIV_B : TDIV_A;
    iotw = sel ? IOTW_B : IOTW_A;
    if (rst) begin
      chk_en    = 1'b1;
      m_busrq_n = 1'b1;
      m_in_cyc  = 1'b0;
      m_turn    = 1'b0;
      m_ack     = 1'b0;
      m_we      = 1'b0;
      m_io      = 1'b0;
      m_k       = 0;
      m_len     = 0;
      m_waits   = 0;
      m_auto    = 0;
      m_a       = 16'h0000;
      m_d       = 8'h00;
      m_rdata   = 8'h00;
    end else begin
      m_ack = 1'b0;
      if (m_in_cyc) begin
        if (m_k == 2 * tdiv - 1 + m_waits * tdiv) begin
          if (m_io && m_auto < iotw) begin
            m_auto++;
            m_waits++;
            m_len += tdiv;
          end else if (WAIT_EN && !wait_n) begin
            m_waits++;
            m_len += tdiv;
          end
        end
        if (m_k == m_len - 1) begin
          m_in_cyc = 1'b0;
          m_turn   = 1'b1;
          m_ack    = 1'b1;
          if (!m_we) m_rdata = d_in;
        end else begin
          m_k++;
        end
      end else if (m_turn) begin
        m_turn = 1'b0;
        if (req) m_start(tdiv);
        else     m_busrq_n = 1'b1;
      end else if (m_busrq_n) begin
        if (req) m_busrq_n = 1'b0;
      end else if (!busak_n) begin
        m_start(tdiv);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int tdiv;
    bit strobe;
    logic [8:0] e_ctl, a_ctl;
    if (chk_en) begin
      tdiv   = sel ? TDIV_B : TDIV_A;
      strobe = m_in_cyc && (m_k >= tdiv);
      e_ctl  = {m_busrq_n, !(strobe && !m_io), !(strobe && m_io), !(strobe && !m_we),
                !(strobe && m_we), 1'b1, m_in_cyc && m_we, m_ack, m_in_cyc};
      a_ctl  = {o_busrq_n, o_mreq_n, o_iorq_n, o_rd_n, o_wr_n, o_rfsh_n, o_doe, o_ack, o_busy};
      n_checks++;
      if (a_ctl !== e_ctl || o_a !== m_a || o_d !== m_d || o_rdata !== m_rdata) begin
        n_fail++;
        $display("FAIL bus_outputs @%0t: actual busrq,mreq,iorq,rd,wr,rfsh,oe,ack,busy=%b a=%h d=%h rdata=%h, required %b a=%h d=%h rdata=%h",
                 $time, a_ctl, o_a, o_d, o_rdata, e_ctl, m_a, m_d, m_rdata);
      end
    end
  end

  // ---------------- bus grant responder ----------------
  bit grant_en = 1'b1;
  int grant_dly = 2;
  initial begin
    int g_cnt;
    g_cnt = 0;
    forever begin
      @(negedge clk);
      if (o_busrq_n === 1'b1) begin
        busak_n = 1'b1;
        g_cnt   = 0;
      end else if (grant_en && busak_n) begin
        g_cnt++;
        if (g_cnt >= grant_dly) busak_n = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  int r_done, r_cycles, r_busy, r_mrd, r_mwr, r_ird, r_iwr, r_mreq, r_iorq;
  int r_doe, r_dbad, r_busrq_hi, r_rdata;

  // Called at a negedge; sets the command immediately and watches until ack.
  task automatic run_cmd(input logic c_we, input logic c_io, input logic [15:0] c_addr,
                         input logic [7:0] c_wdata, input bit keep);
    req = 1'b1; we = c_we; io = c_io; addr = c_addr; wdata = c_wdata;
    r_done = 0; r_cycles = 0; r_busy = 0; r_mrd = 0; r_mwr = 0; r_ird = 0; r_iwr = 0;
    r_mreq = 0; r_iorq = 0; r_doe = 0; r_dbad = 0; r_busrq_hi = 0; r_rdata = 0;
    for (int i = 0; i < 200 && r_done == 0; i++) begin
      @(negedge clk);
      r_cycles++;
      if (o_busy) r_busy++;
      if (!o_mreq_n) r_mreq++;
      if (!o_iorq_n) r_iorq++;
      if (!o_mreq_n && !o_rd_n) r_mrd++;
      if (!o_mreq_n && !o_wr_n) r_mwr++;
      if (!o_iorq_n && !o_rd_n) r_ird++;
      if (!o_iorq_n && !o_wr_n) r_iwr++;
      if (o_doe) begin
        r_doe++;
        if (o_d != c_wdata) r_dbad++;
      end
      if (o_busrq_n) r_busrq_hi++;
      if (o_ack) begin
        r_done  = 1;
        r_rdata = int'(o_rdata);
        if (!keep) req = 1'b0;
      end
    end
    check("ack_seen", r_done, 1);
  endtask

  bit w_seen;
  int hold_busy, hold_strb, hold_rq_lo, rst_acks, b2b_rq_hi1;

  initial begin
    // reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busrq_n", int'(o_busrq_n), 1);
    check("reset_strobes", int'({o_mreq_n, o_iorq_n, o_rd_n, o_wr_n, o_rfsh_n}), 'h1F);
    check("reset_doe_ack_busy", int'({o_doe, o_ack, o_busy}), 0);
    check("reset_a_d_rdata", int'({o_a, o_d, o_rdata}), 0);
    @(negedge clk);

    // memory read 0x2000, d_i = 0xA5, T_DIV=2
    d_in = 8'hA5; grant_dly = 2;
    run_cmd(1'b0, 1'b0, 16'h2000, 8'h00, 1'b0);
    check("mem_rd_strobe_clocks", r_mrd, 4);
    check("mem_rd_busy_clocks", r_busy, 6);
    check("mem_rd_rdata", r_rdata, 'hA5);
    @(negedge clk);
    check("mem_rd_busrq_release", int'(o_busrq_n), 1);
    check("mem_rd_addr_held", int'(o_a), 'h2000);

    // I/O read 0x00BE on T_DIV=2, IO_TW=2
    d_in = 8'h5A;
    run_cmd(1'b0, 1'b1, 16'h00BE, 8'h00, 1'b0);
    check("io_rd_strobe_clocks", r_ird, 8);
    check("io_rd_busy_clocks", r_busy, 10);
    check("io_rd_no_mreq", r_mreq, 0);
    check("io_rd_rdata", r_rdata, 'h5A);
    @(negedge clk);

    // memory read with wait_n_i low for 3 T-states
    d_in = 8'hC3; w_seen = 1'b0;
    fork
      run_cmd(1'b0, 1'b0, 16'h2001, 8'h00, 1'b0);
      begin
        for (int i = 0; i < 100 && !w_seen; i++) begin
          @(negedge clk);
          if (!o_mreq_n) w_seen = 1'b1;
        end
        if (w_seen) begin
          wait_n = 1'b0;
          repeat (3 * TDIV_A) @(negedge clk);
          wait_n = 1'b1;
        end
      end
    join
    check("wait_busy_clocks", r_busy, WAIT_EN ? 12 : 6);
    check("wait_strobe_clocks", r_mrd, WAIT_EN ? 10 : 4);
    check("wait_rdata", r_rdata, 'hC3);
    @(negedge clk);

    // reset during T2 of a write
    req = 1'b1; we = 1'b1; io = 1'b0; addr = 16'h1234; wdata = 8'h99;
    w_seen = 1'b0;
    for (int i = 0; i < 50 && !w_seen; i++) begin
      @(negedge clk);
      if (!o_wr_n) w_seen = 1'b1;
    end
    check("rst_reached_t2", int'(w_seen), 1);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_strobes_high", int'({o_mreq_n, o_iorq_n, o_rd_n, o_wr_n}), 'hF);
    check("rst_doe_low", int'(o_doe), 0);
    check("rst_busrq_high", int'(o_busrq_n), 1);
    rst_acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_ack) rst_acks++;
    end
    check("rst_no_ack", rst_acks, 0);
    run_cmd(1'b1, 1'b0, 16'h1235, 8'h42, 1'b0);
    check("rst_restart_busy_clocks", r_busy, 6);
    check("rst_restart_wr_clocks", r_mwr, 4);
    check("rst_restart_dbad", r_dbad, 0);
    check("rst_restart_rdata_kept", r_rdata, 0);
    @(negedge clk);

    // request held while the CPU withholds BUSAK
    grant_en = 1'b0; d_in = 8'h77;
    req = 1'b1; we = 1'b0; io = 1'b0; addr = 16'h4000;
    hold_busy = 0; hold_strb = 0; hold_rq_lo = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_busy) hold_busy++;
      if (!(o_mreq_n && o_iorq_n && o_rd_n && o_wr_n)) hold_strb++;
      if (!o_busrq_n) hold_rq_lo++;
    end
    check("breq_busy", hold_busy, 0);
    check("breq_strobes", hold_strb, 0);
    check("breq_busrq_low", hold_rq_lo, 20);
    grant_en = 1'b1;
    run_cmd(1'b0, 1'b0, 16'h4000, 8'h00, 1'b0);
    check("breq_then_rdata", r_rdata, 'h77);
    @(negedge clk);

    // switch to instance B (T_DIV=1, IO_TW=1)
    rst = 1'b1;
    @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // I/O write 0x7F <- 0x0F
    run_cmd(1'b1, 1'b1, 16'h007F, 8'h0F, 1'b0);
    check("io_wr_strobe_clocks", r_iwr, 3);
    check("io_wr_doe_clocks", r_doe, 4);
    check("io_wr_d_bad", r_dbad, 0);
    check("io_wr_no_mreq", r_mreq, 0);
    check("io_wr_busy_clocks", r_busy, 4);
    @(negedge clk);

    // back-to-back write 0x8000 <- 0x11 then read 0x8000
    d_in = 8'h3C;
    run_cmd(1'b1, 1'b0, 16'h8000, 8'h11, 1'b1);
    b2b_rq_hi1 = r_busrq_hi;
    check("b2b_wr_clocks", r_mwr, 2);
    run_cmd(1'b0, 1'b0, 16'h8000, 8'h00, 1'b0);
    check("b2b_busrq_held_1", b2b_rq_hi1, 0);
    check("b2b_busrq_held_2", r_busrq_hi, 0);
    check("b2b_ack_spacing", r_cycles, 4);
    check("b2b_rd_rdata", r_rdata, 'h3C);
    @(negedge clk);
    check("b2b_busrq_release", int'(o_busrq_n), 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: actual time %0t, required completion before it", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
